risc_v_alu_pipe: RTL and testbench
==================================

Name: risc_v_alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational RISC-V ALU.
- Same operand-conditioning controls (nx/ix/sx, ny/iy/sy) and the same 4-bit opcode map, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, full backpressure, a registered flag bundle and defined behaviour for illegal opcodes.
- Sits between the decode/issue stage and writeback in the pipelined core.

Parameters:
- WIDTH, 32: datapath width in bits; at least 8; power of two.
- IMM_W, 12: immediate field width used by sx/sy sign extension; IMM_W < WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts the operation this cycle
- x  in  WIDTH  operand X
- y  in  WIDTH  operand Y
- nx, ix, sx  in  1 each  negate / increment / sign-extend X
- ny, iy, sy  in  1 each  negate / increment / sign-extend Y
- opcode  in  4  operation select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- zero_flag  out  1  out == 0
- negative_flag  out  1  out[WIDTH-1]
- carry_flag  out  1  adder carry, see below
- overflow_flag  out  1  signed overflow, add/sub only
- illegal_flag  out  1  opcode 14 or 15

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high: on a clk edge with reset=1, s1_valid, s2_valid and out_valid go to 0, and out plus all flags go to 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Reset mid-operation drops all in-flight operations; no result is emitted for them.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - s2 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || s2 advances. This is combinational from out_ready; no skid buffer.
  - out and flags are held stable while out_valid && !out_ready.
  - Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 operation per cycle.
  - Simultaneous accept and drain in the same cycle is allowed at both stages.
- Stage 1, operand conditioning, registered into s1 on input transfer:
  - Sign extension first: if sx=1, X' = {replicate x[IMM_W-1] to WIDTH-IMM_W bits, x[IMM_W-1:0]}, else X' = x.
  - Then negation: if nx=1, X'' = ~X'.
  - Then increment: if ix=1, A = X'' + 1, modulo 2^WIDTH.
  - B is formed from y with sy/ny/iy in the same way.
  - s1 stores A, B and opcode. The operand sign bits are A[WIDTH-1] and B[WIDTH-1].
- Stage 2, execute, registered into out and flags when s2 advances with s1_valid:
  - 0 ADD: A + B.
  - 1 SUB: A - B, computed as A + ~B + 1.
  - 2 SLL: A << sh. 3 SRL: A >> sh, logical. 4 SRA: A >>> sh, arithmetic. sh = B[log2(WIDTH)-1:0]; upper bits of B are ignored.
  - 5 EQ, 6 NE, 7 LT signed, 8 GE signed, 9 LTU, 10 GEU: result is 1 or 0, zero-extended to WIDTH.
  - 11 AND, 12 OR, 13 XOR.
  - 14, 15: out = 0, illegal_flag = 1. This is a pure result; the block does not stall or stop.
- Flags:
  - carry_flag: for ADD, carry-out of bit WIDTH-1; for SUB, 1 means no borrow (A >= B unsigned); 0 for all other opcodes.
  - overflow_flag: for ADD, 1 when A and B have the same sign and the result sign differs; for SUB, 1 when A and B have different signs and the result sign differs from A; 0 for all other opcodes.
  - zero_flag and negative_flag are computed from out for every opcode, including illegal ones (zero_flag = 1 there).
  - illegal_flag is 0 for opcodes 0-13.
- Data is not checked while out_valid = 0; the bench must not check out when out_valid is low.

Test Plan:
- Reset then ADD: x=7, y=5, all controls 0, opcode 0 -> out_valid 2 cycles after accept; out=12; zero, carry and overflow flags 0.
- Conditioned SUB via add: x=10, y=3, ny=1, iy=1, opcode 0 -> out=7, carry_flag=1. Then opcode 1, x=3, y=10 -> out=0xFFFFFFF9, negative=1, carry=0.
- Overflow and immediate: x=0x7FFFFFFF, y=1, ADD -> out=0x80000000, overflow=1. Then y=0xFFF, sy=1, ADD with x=1 -> out=0, zero=1, carry=1.
- Shift and compare: x=0x80000000, y=0x21, SRA -> out=0xC0000000 (sh=1). Then x=0xFFFFFFFF, y=1, LT -> out=1; LTU -> out=0.
- Backpressure: issue 4 back-to-back ADDs, hold out_ready=0 for 3 cycles. Required: in_ready=0 after 2 accepts, out held stable, then all 4 results delivered in order with no loss or duplication.
- Illegal opcode and mid-flight reset: opcode 15 -> out=0, illegal_flag=1, zero_flag=1. Then reset asserted with 2 operations in flight -> out_valid=0 next cycle and neither result is ever emitted.

Source files
------------

// File: rtl/risc_v_alu_pipe.sv
// Two-stage pipelined RISC-V ALU: operand conditioning in stage 1, execute and
// flag generation in stage 2, with valid/ready handshakes and full backpressure.
module risc_v_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             nx,
    input  logic             ix,
    input  logic             sx,
    input  logic             ny,
    input  logic             iy,
    input  logic             sy,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             illegal_flag
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_C = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_SRL   = 4'd3,
        OP_SRA   = 4'd4,
        OP_EQ    = 4'd5,
        OP_NE    = 4'd6,
        OP_LT    = 4'd7,
        OP_GE    = 4'd8,
        OP_LTU   = 4'd9,
        OP_GEU   = 4'd10,
        OP_AND   = 4'd11,
        OP_OR    = 4'd12,
        OP_XOR   = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_e;

    // Order matters: sign-extend the immediate, then invert, then add one.
    function automatic logic [WIDTH-1:0] condition(input logic [WIDTH-1:0] v,
                                                   input logic neg,
                                                   input logic inc,
                                                   input logic sext);
        logic [WIDTH-1:0] r;
        r = sext ? {{(WIDTH-IMM_W){v[IMM_W-1]}}, v[IMM_W-1:0]} : v;
        if (neg) r = ~r;
        if (inc) r = r + ONE;
        return r;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    logic s2_adv;
    logic in_fire;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= condition(x, nx, ix, sx);
            s1_b     <= condition(y, ny, iy, sy);
            s1_op    <= op_e'(opcode);
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [SH_W-1:0]  sh;
    logic             sign_a;
    logic             sign_b;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;
    logic             res_ill;

    always_comb begin
        sum       = {1'b0, s1_a} + {1'b0, s1_b};
        dif       = {1'b0, s1_a} + {1'b0, ~s1_b} + ONE_C;
        sh        = s1_b[SH_W-1:0];
        sign_a    = s1_a[WIDTH-1];
        sign_b    = s1_b[WIDTH-1];
        lt_s      = $signed(s1_a) < $signed(s1_b);
        lt_u      = s1_a < s1_b;
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_ill   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
            end
            OP_SUB: begin
                // Carry-out of A + ~B + 1 is set exactly when no borrow occurs.
                res       = dif[WIDTH-1:0];
                res_carry = dif[WIDTH];
                res_ovf   = (sign_a != sign_b) && (dif[WIDTH-1] != sign_a);
            end
            OP_SLL:  res = s1_a << sh;
            OP_SRL:  res = s1_a >> sh;
            OP_SRA:  res = WIDTH'($signed(s1_a) >>> sh);
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, s1_a == s1_b};
            OP_NE:   res = {{(WIDTH-1){1'b0}}, s1_a != s1_b};
            OP_LT:   res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_GE:   res = {{(WIDTH-1){1'b0}}, !lt_s};
            OP_LTU:  res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_GEU:  res = {{(WIDTH-1){1'b0}}, !lt_u};
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            default: res_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out           <= '0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            illegal_flag  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out           <= res;
                zero_flag     <= (res == '0);
                negative_flag <= res[WIDTH-1];
                carry_flag    <= res_carry;
                overflow_flag <= res_ovf;
                illegal_flag  <= res_ill;
            end
        end
    end

endmodule

// File: tb/tb_risc_v_alu_pipe.sv
// Self-checking bench for risc_v_alu_pipe: directed vectors, an arithmetic
// reference model with an in-order expectation queue, and literal pins.
module tb_risc_v_alu_pipe;

    localparam int W  = 32;
    localparam int IW = 12;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));
    localparam longint TWO_W = longint'(1) << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         nx, ix, sx, ny, iy, sy;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero_flag, negative_flag, carry_flag, overflow_flag, illegal_flag;

    risc_v_alu_pipe #(.WIDTH(W), .IMM_W(IW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y),
        .nx(nx), .ix(ix), .sx(sx), .ny(ny), .iy(iy), .sy(sy),
        .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zero_flag(zero_flag), .negative_flag(negative_flag),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .illegal_flag(illegal_flag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int del_cnt = 0;

    // Flags packed as {zero, negative, carry, overflow, illegal}.
    typedef struct {
        logic [W-1:0] out;
        logic [4:0]   fl;
        logic         has_lit;
        logic [W-1:0] lout;
        logic [4:0]   lfl;
    } exp_t;

    exp_t q[$];

    logic         lit_has = 1'b0;
    logic [W-1:0] lit_out = '0;
    logic [4:0]   lit_fl  = '0;

    function automatic logic [W-1:0] cond(input logic [W-1:0] v, input logic n,
                                          input logic i, input logic s);
        logic signed [IW-1:0] imm;
        longint               li;
        logic [W-1:0]         r;
        imm = v[IW-1:0];
        li  = imm;
        r   = s ? li[W-1:0] : v;
        if (n) r = ~r;
        if (i) r = r + 1;
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op);
        exp_t                e;
        logic signed [W-1:0] as_w;
        logic signed [W-1:0] bs_w;
        longint              sa, sb, s;
        longint unsigned     ua, ub, r;
        int                  sh;
        logic                c, v, il;
        as_w = a;  bs_w = b;
        sa = as_w; sb = bs_w;
        ua = a;    ub = b;
        sh = int'(ub % W);
        c = 0; v = 0; il = 0; r = 0;
        case (op)
            4'd0: begin r = ua + ub; c = (ua + ub) >= TWO_W; s = sa + sb; v = (s > MAXS) || (s < MINS); end
            4'd1: begin r = ua - ub; c = (ua >= ub); s = sa - sb; v = (s > MAXS) || (s < MINS); end
            4'd2: r = ua << sh;
            4'd3: r = ua >> sh;
            4'd4: r = longint'(sa >>> sh);
            4'd5: r = (ua == ub) ? 1 : 0;
            4'd6: r = (ua != ub) ? 1 : 0;
            4'd7: r = (sa < sb) ? 1 : 0;
            4'd8: r = (sa >= sb) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
            4'd10: r = (ua >= ub) ? 1 : 0;
            4'd11: r = ua & ub;
            4'd12: r = ua | ub;
            4'd13: r = ua ^ ub;
            default: begin r = 0; il = 1; end
        endcase
        e.out = r[W-1:0];
        e.fl  = {e.out == 0, e.out[W-1], c, v, il};
        e.has_lit = 0;
        e.lout = '0;
        e.lfl  = '0;
        return e;
    endfunction

    logic         stalled = 1'b0;
    logic [W-1:0] held_out;
    logic [4:0]   held_fl;

    always @(negedge clk) begin
        logic [4:0] fl;
        exp_t       e;
        fl = {zero_flag, negative_flag, carry_flag, overflow_flag, illegal_flag};
        if (reset) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!out_valid || out !== held_out || fl !== held_fl) begin
                    errors++;
                    $display("FAIL hold: got v=%b out=%h fl=%b required v=1 out=%h fl=%b",
                             out_valid, out, fl, held_out, held_fl);
                end
            end
            if (in_valid && in_ready) begin
                e = model(cond(x, nx, ix, sx), cond(y, ny, iy, sy), opcode);
                e.has_lit = lit_has;
                e.lout    = lit_out;
                e.lfl     = lit_fl;
                q.push_back(e);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                del_cnt++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got out=%h with no operation outstanding", out);
                end else begin
                    e = q.pop_front();
                    if (out !== e.out || fl !== e.fl) begin
                        errors++;
                        $display("FAIL result: got out=%h fl=%b required out=%h fl=%b",
                                 out, fl, e.out, e.fl);
                    end
                    if (e.has_lit) begin
                        checks++;
                        if (out !== e.lout || fl !== e.lfl) begin
                            errors++;
                            $display("FAIL literal: got out=%h fl=%b required out=%h fl=%b",
                                     out, fl, e.lout, e.lfl);
                        end
                    end
                end
            end
            stalled  = out_valid && !out_ready;
            held_out = out;
            held_fl  = fl;
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // ctl = {nx, ix, sx, ny, iy, sy}; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [5:0] ctl,
                         input logic [3:0] op, input logic hl, input logic [W-1:0] lo,
                         input logic [4:0] lf);
        int fired;
        int n;
        x = xv; y = yv; opcode = op;
        {nx, ix, sx, ny, iy, sy} = ctl;
        lit_has = hl; lit_out = lo; lit_fl = lf;
        in_valid = 1'b1;
        fired = 0;
        n = 0;
        while (fired == 0 && n < 50) begin
            @(negedge clk);
            fired = in_ready ? 1 : 0;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        lit_has  = 1'b0;
        check("issue_accept", 32'(fired), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [W-1:0] xa[5] = '{32'h1234_5678, 32'h8000_0001, 32'h0000_0005, 32'hFFFF_F800, 32'h8000_0000};
    logic [W-1:0] ya[5] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_07FF, 32'h0000_0001};
    logic [5:0]   ca[5] = '{6'b000000, 6'b100000, 6'b110000, 6'b001001, 6'b000000};

    initial begin
        int base_acc;
        int base_del;
        int n;
        logic done;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; opcode = '0;
        {nx, ix, sx, ny, iy, sy} = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", out, 32'd0);
        check("reset_flags", 32'({zero_flag, negative_flag, carry_flag, overflow_flag, illegal_flag}), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        issue(32'd7, 32'd5, 6'b000000, 4'd0, 1'b1, 32'd12, 5'b00000);
        check("latency_cycle1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_cycle2", 32'(out_valid), 32'd1);

        issue(32'd10, 32'd3, 6'b000110, 4'd0, 1'b1, 32'd7, 5'b00100);
        issue(32'd3, 32'd10, 6'b000000, 4'd1, 1'b1, 32'hFFFF_FFF9, 5'b01000);
        issue(32'h7FFF_FFFF, 32'd1, 6'b000000, 4'd0, 1'b1, 32'h8000_0000, 5'b01010);
        issue(32'd1, 32'h0000_0FFF, 6'b000001, 4'd0, 1'b1, 32'd0, 5'b10100);
        issue(32'h8000_0000, 32'h0000_0021, 6'b000000, 4'd4, 1'b1, 32'hC000_0000, 5'b01000);
        issue(32'hFFFF_FFFF, 32'd1, 6'b000000, 4'd7, 1'b1, 32'd1, 5'b00000);
        issue(32'hFFFF_FFFF, 32'd1, 6'b000000, 4'd9, 1'b1, 32'd0, 5'b10000);
        issue(32'h0000_1234, 32'h0000_5678, 6'b000000, 4'd15, 1'b1, 32'd0, 5'b10001);
        drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    for (int op = 0; op < 16; op++)
                        issue(xa[i], ya[i], ca[i], 4'(op), 1'b0, '0, '0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        base_acc = acc_cnt;
        base_del = del_cnt;
        out_ready = 1'b0;
        fork
            begin
                issue(32'd100, 32'd1, 6'b000000, 4'd0, 1'b0, '0, '0);
                issue(32'd200, 32'd2, 6'b000000, 4'd0, 1'b0, '0, '0);
                issue(32'd300, 32'd3, 6'b000000, 4'd0, 1'b0, '0, '0);
                issue(32'd400, 32'd4, 6'b000000, 4'd0, 1'b0, '0, '0);
            end
            begin
                n = 0;
                while (acc_cnt < base_acc + 2 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                end
                check("bp_accepts", 32'(acc_cnt - base_acc), 32'd2);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", 32'(del_cnt - base_del), 32'd4);

        out_ready = 1'b0;
        issue(32'd11, 32'd22, 6'b000000, 4'd0, 1'b0, '0, '0);
        issue(32'd33, 32'd44, 6'b000000, 4'd13, 1'b0, '0, '0);
        base_del = del_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_output", 32'(del_cnt - base_del), 32'd0);
        check("midreset_out_valid_idle", 32'(out_valid), 32'd0);

        issue(32'd1, 32'd2, 6'b000000, 4'd0, 1'b1, 32'd3, 5'b00000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
